key_hold_decoder: RTL and testbench

KEY_HOLD_DECODER -- requirements
Module: key_hold_decoder

---
 rtl/key_hold_decoder.sv | 184 ++++++++++++++++++
 tb/tb_key_hold_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_hold_decoder.sv
// ---------------------------------------------------------------------------
// key_hold_decoder
//
// Purpose:
//   Turns a stream of UART bytes into held-key levels for a two-player game.
//   Each press byte keeps its key held for HOLD_CYCLES clocks. A repeat press
//   (keyboard auto-repeat) restarts that window. An uppercase release byte or
//   ESC drops the key at once. Opposing directions of one player cancel each
//   other, and the last press wins. Bytes that are not recognised are counted
//   in a saturating counter.
//
// Ports:
//   clk            system clock, rising edge
//   rstn           asynchronous active-low reset
//   rx_data[7:0]   received byte, qualified by rx_valid
//   rx_valid       one-cycle strobe for a new byte
//   p1_* / p2_*    registered held-key levels (up, down, left, right, fire)
//   p1_fire_pulse  one-cycle strobe on a fresh player-1 fire press
//   p2_fire_pulse  one-cycle strobe on a fresh player-2 fire press
//   any_key        registered OR of all ten levels
//   unknown_cnt    saturating count of unrecognised bytes
// ---------------------------------------------------------------------------
module key_hold_decoder #(
  parameter int unsigned HOLD_CYCLES = 10_000_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p1_fire,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right,
  output logic       p2_fire,
  output logic       p1_fire_pulse,
  output logic       p2_fire_pulse,
  output logic       any_key,
  output logic [7:0] unknown_cnt
);

  localparam int NKEYS = 10;

  localparam int P1_UP    = 0;
  localparam int P1_DOWN  = 1;
  localparam int P1_LEFT  = 2;
  localparam int P1_RIGHT = 3;
  localparam int P1_FIRE  = 4;
  localparam int P2_UP    = 5;
  localparam int P2_DOWN  = 6;
  localparam int P2_LEFT  = 7;
  localparam int P2_RIGHT = 8;
  localparam int P2_FIRE  = 9;

  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] rel;
  logic [NKEYS-1:0] clear;
  logic             unknown;

  logic [CNT_W-1:0] cnt_q [NKEYS];
  logic [CNT_W-1:0] cnt_d [NKEYS];
  logic [NKEYS-1:0] level_q;
  logic [NKEYS-1:0] level_d;
  logic [1:0]       pulse_q;
  logic [1:0]       pulse_d;
  logic             any_q;
  logic [7:0]       unk_q;

  // Byte decode. ESC sets every release bit. Any byte that is neither a
  // press nor a release counts as unknown.
  always_comb begin
    press   = '0;
    rel     = '0;
    unknown = 1'b0;
    if (rx_valid) begin
      case (rx_data)
        8'h77: press[P1_UP]    = 1'b1;
        8'h73: press[P1_DOWN]  = 1'b1;
        8'h61: press[P1_LEFT]  = 1'b1;
        8'h64: press[P1_RIGHT] = 1'b1;
        8'h20: press[P1_FIRE]  = 1'b1;
        8'h69: press[P2_UP]    = 1'b1;
        8'h6B: press[P2_DOWN]  = 1'b1;
        8'h6A: press[P2_LEFT]  = 1'b1;
        8'h6C: press[P2_RIGHT] = 1'b1;
        8'h6F: press[P2_FIRE]  = 1'b1;
        8'h57: rel[P1_UP]      = 1'b1;
        8'h53: rel[P1_DOWN]    = 1'b1;
        8'h41: rel[P1_LEFT]    = 1'b1;
        8'h44: rel[P1_RIGHT]   = 1'b1;
        8'h5F: rel[P1_FIRE]    = 1'b1;
        8'h49: rel[P2_UP]      = 1'b1;
        8'h4B: rel[P2_DOWN]    = 1'b1;
        8'h4A: rel[P2_LEFT]    = 1'b1;
        8'h4C: rel[P2_RIGHT]   = 1'b1;
        8'h4F: rel[P2_FIRE]    = 1'b1;
        8'h1B: rel             = '1;
        default: unknown       = 1'b1;
      endcase
    end
  end

  // A press of one direction clears the opposing direction of the same
  // player in the same cycle, so that the last press wins.
  always_comb begin
    clear           = rel;
    clear[P1_UP]    = rel[P1_UP]    | press[P1_DOWN];
    clear[P1_DOWN]  = rel[P1_DOWN]  | press[P1_UP];
    clear[P1_LEFT]  = rel[P1_LEFT]  | press[P1_RIGHT];
    clear[P1_RIGHT] = rel[P1_RIGHT] | press[P1_LEFT];
    clear[P2_UP]    = rel[P2_UP]    | press[P2_DOWN];
    clear[P2_DOWN]  = rel[P2_DOWN]  | press[P2_UP];
    clear[P2_LEFT]  = rel[P2_LEFT]  | press[P2_RIGHT];
    clear[P2_RIGHT] = rel[P2_RIGHT] | press[P2_LEFT];
  end

  // Next value of each counter. A press has priority over the decrement, so
  // a press that arrives on the cycle the hold would run out reloads it.
  // The registered levels and any_key come from the next counter values.
  // Each level therefore matches its counter in every cycle.
  always_comb begin
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (press[i]) begin
        cnt_d[i] = HOLD_VAL;
      end else if (clear[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
      level_d[i] = (cnt_d[i] != '0);
    end
    pulse_d[0] = press[P1_FIRE] & ~level_q[P1_FIRE];
    pulse_d[1] = press[P2_FIRE] & ~level_q[P2_FIRE];
  end

  // State registers. Reset clears everything, including any hold in
  // progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      unk_q   <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q <= level_d;
      pulse_q <= pulse_d;
      any_q   <= |level_d;
      if (unknown && (unk_q != 8'hFF)) begin
        unk_q <= unk_q + 8'd1;
      end
    end
  end

  assign p1_up         = level_q[P1_UP];
  assign p1_down       = level_q[P1_DOWN];
  assign p1_left       = level_q[P1_LEFT];
  assign p1_right      = level_q[P1_RIGHT];
  assign p1_fire       = level_q[P1_FIRE];
  assign p2_up         = level_q[P2_UP];
  assign p2_down       = level_q[P2_DOWN];
  assign p2_left       = level_q[P2_LEFT];
  assign p2_right      = level_q[P2_RIGHT];
  assign p2_fire       = level_q[P2_FIRE];
  assign p1_fire_pulse = pulse_q[0];
  assign p2_fire_pulse = pulse_q[1];
  assign any_key       = any_q;
  assign unknown_cnt   = unk_q;

endmodule

// File: tb/tb_key_hold_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_hold_decoder
//
// Purpose:
//   Self-checking bench for key_hold_decoder with HOLD_CYCLES = 16.
//   A table of single-byte vectors covers the press and release maps,
//   opposing directions, fire pulses and unknown bytes. Hand-written
//   sequences cover hold length, repeat presses, the reload that competes
//   with a counter running out, saturation of unknown_cnt and mid-hold reset.
//
// Level bit order in the bench:
//   0 p1_up  1 p1_down  2 p1_left  3 p1_right  4 p1_fire
//   5 p2_up  6 p2_down  7 p2_left  8 p2_right  9 p2_fire
// ---------------------------------------------------------------------------
module tb_key_hold_decoder;

  localparam int unsigned HOLD = 16;

  logic       clk;
  logic       rstn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       p1_up, p1_down, p1_left, p1_right, p1_fire;
  logic       p2_up, p2_down, p2_left, p2_right, p2_fire;
  logic       p1_fire_pulse, p2_fire_pulse;
  logic       any_key;
  logic [7:0] unknown_cnt;

  int checks;
  int errors;
  int exp_unk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [9:0] lv;
    logic [1:0] pl;
    logic [7:0] unk;
  } vec_t;

  vec_t vecs [22];

  key_hold_decoder #(
    .HOLD_CYCLES(HOLD),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .p1_up(p1_up),
    .p1_down(p1_down),
    .p1_left(p1_left),
    .p1_right(p1_right),
    .p1_fire(p1_fire),
    .p2_up(p2_up),
    .p2_down(p2_down),
    .p2_left(p2_left),
    .p2_right(p2_right),
    .p2_fire(p2_fire),
    .p1_fire_pulse(p1_fire_pulse),
    .p2_fire_pulse(p2_fire_pulse),
    .any_key(any_key),
    .unknown_cnt(unknown_cnt)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input at the falling edge. Then sample the outputs
  // just after the rising edge that captured it.
  task automatic apply_stimulus(input logic valid, input logic [7:0] data);
    @(negedge clk);
    rx_valid = valid;
    rx_data  = data;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 8'h00);
  endtask

  // Compare every output against the expected levels, pulses and unknown
  // count. The expected any_key is the OR of the expected levels.
  task automatic check_output(input string name, input logic [9:0] e_lv,
                              input logic [1:0] e_pl, input logic [7:0] e_unk);
    logic [20:0] act;
    logic [20:0] exp_v;
    act   = {p2_fire, p2_right, p2_left, p2_down, p2_up,
             p1_fire, p1_right, p1_left, p1_down, p1_up,
             p2_fire_pulse, p1_fire_pulse, any_key, unknown_cnt};
    exp_v = {e_lv, e_pl, |e_lv, e_unk};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got lv=%h pl=%b any=%b unk=%0d, expected lv=%h pl=%b any=%b unk=%0d",
               name, act[20:11], act[10:9], act[8], act[7:0],
               e_lv, e_pl, |e_lv, e_unk);
    end
  endtask

  // Press 'w'. If gap > 0, press 'w' again gap cycles later. Then check that
  // p1_up stays high for exactly HOLD cycles after the last press.
  task automatic hold_run(input string name, input int gap);
    apply_stimulus(1'b1, 8'h77);
    check_output(name, 10'h001, 2'b00, 8'(exp_unk));
    if (gap > 0) begin
      for (int k = 1; k < gap; k++) begin
        idle_cycle();
        check_output(name, 10'h001, 2'b00, 8'(exp_unk));
      end
      apply_stimulus(1'b1, 8'h77);
      check_output(name, 10'h001, 2'b00, 8'(exp_unk));
    end
    for (int k = 1; k < int'(HOLD); k++) begin
      idle_cycle();
      check_output(name, 10'h001, 2'b00, 8'(exp_unk));
    end
    idle_cycle();
    check_output({name, "_expire"}, 10'h000, 2'b00, 8'(exp_unk));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_unk  = 0;
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Single-byte vectors. Expected values apply after the capturing edge.
    vecs[0]  = '{1'b1, 8'h77, 10'h001, 2'b00, 8'd0};
    vecs[1]  = '{1'b1, 8'h73, 10'h002, 2'b00, 8'd0};
    vecs[2]  = '{1'b1, 8'h53, 10'h000, 2'b00, 8'd0};
    vecs[3]  = '{1'b1, 8'h61, 10'h004, 2'b00, 8'd0};
    vecs[4]  = '{1'b1, 8'h64, 10'h008, 2'b00, 8'd0};
    vecs[5]  = '{1'b1, 8'h77, 10'h009, 2'b00, 8'd0};
    vecs[6]  = '{1'b1, 8'h20, 10'h019, 2'b01, 8'd0};
    vecs[7]  = '{1'b1, 8'h20, 10'h019, 2'b00, 8'd0};
    vecs[8]  = '{1'b1, 8'h6F, 10'h219, 2'b10, 8'd0};
    vecs[9]  = '{1'b0, 8'h69, 10'h219, 2'b00, 8'd0};
    vecs[10] = '{1'b1, 8'h7A, 10'h219, 2'b00, 8'd1};
    vecs[11] = '{1'b1, 8'h4F, 10'h019, 2'b00, 8'd1};
    vecs[12] = '{1'b1, 8'h5F, 10'h009, 2'b00, 8'd1};
    vecs[13] = '{1'b1, 8'h69, 10'h029, 2'b00, 8'd1};
    vecs[14] = '{1'b1, 8'h6B, 10'h049, 2'b00, 8'd1};
    vecs[15] = '{1'b1, 8'h6A, 10'h0C9, 2'b00, 8'd1};
    vecs[16] = '{1'b1, 8'h6C, 10'h149, 2'b00, 8'd1};
    vecs[17] = '{1'b1, 8'h57, 10'h148, 2'b00, 8'd1};
    vecs[18] = '{1'b1, 8'h44, 10'h140, 2'b00, 8'd1};
    vecs[19] = '{1'b1, 8'h1B, 10'h000, 2'b00, 8'd1};
    vecs[20] = '{1'b1, 8'h57, 10'h000, 2'b00, 8'd1};
    vecs[21] = '{1'b1, 8'h51, 10'h000, 2'b00, 8'd2};

    // Outputs must be zero while reset is held.
    repeat (3) @(negedge clk);
    check_output("reset_state", 10'h000, 2'b00, 8'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].data);
      check_output($sformatf("vec%0d", i), vecs[i].lv, vecs[i].pl, vecs[i].unk);
    end
    exp_unk = 2;

    hold_run("hold_single", 0);
    hold_run("hold_repeat10", 10);
    hold_run("hold_reload_at_zero", 16);

    // A release of a key that is not held is a known byte. It must not
    // change any level or the unknown count.
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b1, 8'h41);
    end
    check_output("release_not_held", 10'h000, 2'b00, 8'(exp_unk));

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b1, 8'h7A);
      if (exp_unk < 255) exp_unk++;
      check_output("unknown_sat", 10'h000, 2'b00, 8'(exp_unk));
    end

    // Reset asserted in the middle of a hold.
    apply_stimulus(1'b1, 8'h64);
    check_output("pre_reset_hold", 10'h008, 2'b00, 8'd255);
    repeat (3) idle_cycle();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_output("async_reset", 10'h000, 2'b00, 8'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_unk = 0;
    for (int i = 0; i < 20; i++) begin
      idle_cycle();
      check_output("post_reset_quiet", 10'h000, 2'b00, 8'd0);
    end
    apply_stimulus(1'b1, 8'h77);
    check_output("post_reset_first_byte", 10'h001, 2'b00, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
